// File: rtl/countdown_timer.sv
// countdown_timer
// MM:SS countdown held as four BCD digits, decremented once per one-second
// pulse while running. Load/start/stop come from the user-input logic and
// expiry is reported to the game/system controller.
// Optional feature: define COUNTDOWN_WARN_EN to build the low-time warning
// output (remaining time <= WARN_SECS while running or paused). Without the
// macro, warn is tied low and no warning comparator is built.

module countdown_timer #(
  parameter int WARN_SECS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        OneSecTimeout,
  input  logic        load,
  input  logic [15:0] load_bcd,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        running,
  output logic        time_up,
  output logic        expired,
  output logic        load_err,
  output logic        warn
);

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Run     = 2'd1,
    Pause   = 2'd2,
    Expired = 2'd3
  } stateT;

  stateT stateQ, stateD;

  logic [3:0] nextMinTens, nextMinOnes, nextSecTens, nextSecOnes;
  logic [3:0] decMinTens, decMinOnes, decSecTens, decSecOnes;
  logic       loadValid;
  logic       curNonZero;
  logic       decZero;
  logic       expiredD;
  logic       loadErrD;

  // A WARN_SECS outside 1..59 could never (or would always) fire; catch it
  // when the design is elaborated rather than in the field.
  if (WARN_SECS < 1 || WARN_SECS > 59) begin : gWarnRangeCheck
    $error("countdown_timer: WARN_SECS must be in 1..59");
  end

  // Load is accepted only as a legal MM:SS value in BCD.
  always_comb begin
    loadValid = (load_bcd[15:12] <= 4'd9) && (load_bcd[11:8] <= 4'd9) &&
                (load_bcd[7:4] <= 4'd5) && (load_bcd[3:0] <= 4'd9);
    curNonZero = |{min_tens, min_ones, sec_tens, sec_ones};
  end

  // One-second BCD decrement with borrow chain: 9 for ones digits, 5 for sec tens.
  always_comb begin
    decMinTens = min_tens;
    decMinOnes = min_ones;
    decSecTens = sec_tens;
    decSecOnes = sec_ones;
    if (sec_ones != 4'd0) begin
      decSecOnes = sec_ones - 4'd1;
    end else begin
      decSecOnes = 4'd9;
      if (sec_tens != 4'd0) begin
        decSecTens = sec_tens - 4'd1;
      end else begin
        decSecTens = 4'd5;
        if (min_ones != 4'd0) begin
          decMinOnes = min_ones - 4'd1;
        end else begin
          decMinOnes = 4'd9;
          decMinTens = min_tens - 4'd1;
        end
      end
    end
    decZero = ~|{decMinTens, decMinOnes, decSecTens, decSecOnes};
  end

  // Next-state and next-digit logic; load beats start, stop beats start,
  // and reaching 00:00 beats a simultaneous stop.
  always_comb begin
    stateD      = stateQ;
    nextMinTens = min_tens;
    nextMinOnes = min_ones;
    nextSecTens = sec_tens;
    nextSecOnes = sec_ones;
    expiredD    = 1'b0;
    loadErrD    = 1'b0;
    unique case (stateQ)
      Idle: begin
        if (load) begin
          if (loadValid) begin
            {nextMinTens, nextMinOnes, nextSecTens, nextSecOnes} = load_bcd;
          end else begin
            loadErrD = 1'b1;
          end
        end else if (start && !stop && curNonZero) begin
          stateD = Run;
        end
      end
      Run: begin
        if (OneSecTimeout) begin
          nextMinTens = decMinTens;
          nextMinOnes = decMinOnes;
          nextSecTens = decSecTens;
          nextSecOnes = decSecOnes;
          if (decZero) begin
            stateD   = Expired;
            expiredD = 1'b1;
          end else if (stop) begin
            stateD = Pause;
          end
        end else if (stop) begin
          stateD = Pause;
        end
      end
      Pause: begin
        if (load) begin
          if (loadValid) begin
            {nextMinTens, nextMinOnes, nextSecTens, nextSecOnes} = load_bcd;
            stateD = Idle;
          end else begin
            loadErrD = 1'b1;
          end
        end else if (start && !stop) begin
          stateD = Run;
        end
      end
      Expired: begin
        if (load) begin
          if (loadValid) begin
            {nextMinTens, nextMinOnes, nextSecTens, nextSecOnes} = load_bcd;
            stateD = Idle;
          end else begin
            loadErrD = 1'b1;
          end
        end
      end
      default: begin
        stateD = Idle;
      end
    endcase
  end

  // State, digits and status flags all register together so they change on one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= Idle;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      running  <= 1'b0;
      time_up  <= 1'b0;
      expired  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      stateQ   <= stateD;
      min_tens <= nextMinTens;
      min_ones <= nextMinOnes;
      sec_tens <= nextSecTens;
      sec_ones <= nextSecOnes;
      running  <= (stateD == Run);
      time_up  <= (stateD == Expired);
      expired  <= expiredD;
      load_err <= loadErrD;
    end
  end

`ifdef COUNTDOWN_WARN_EN
  localparam logic [6:0] WarnLimit = 7'(WARN_SECS);

  logic [6:0] nextSecs;
  logic       warnD;

  // Warning looks at the upcoming digits so it lines up with the display.
  always_comb begin
    nextSecs = 7'(nextSecTens) * 7'd10 + 7'(nextSecOnes);
    warnD    = ((stateD == Run) || (stateD == Pause)) &&
               (nextMinTens == 4'd0) && (nextMinOnes == 4'd0) &&
               (nextSecs != 7'd0) && (nextSecs <= WarnLimit);
  end

  // Warning flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warn <= 1'b0;
    end else begin
      warn <= warnD;
    end
  end
`else
  assign warn = 1'b0;
`endif

endmodule
